// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: requester ids, read-return tags
// and drain FSM states.
package dmem_arb_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_LDR  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } drain_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_CORE) ? OWN_LDR : OWN_CORE;
  endfunction

endpackage

// File: rtl/dmem_rd_tag_pipe.sv
// Delay line carrying {valid, owner} for every issued read, so the returning
// memory data can be steered to the requester that issued it.
module dmem_rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t push,
  output rd_tag_t pop,
  output logic    empty
);

  rd_tag_t stage [DEPTH];

  // NOTE: this array is a handful of flops, not a RAM, and every entry must be
  // cleared so that reads in flight at reset never return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage shift from the old
      // value of its neighbour, giving a true shift register.
      stage[0] <= push;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign pop = stage[DEPTH-1];

  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (stage[i].valid) empty = 1'b0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (core, loader) arbiter for the single-port data memory with
// registered commands, tagged read return and a drain/idle handshake.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is core-first.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ready,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ready,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              m_wr,
  output logic              m_rd,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wr_data,
  input  logic [DATA_W-1:0] m_rd_data,
  input  logic              drain,
  output logic              idle
);

  drain_state_e state, state_nxt;
  logic         accept_en;
  logic         grant_c, grant_l;
  logic         pipe_empty;
  rd_tag_t      tag_push, tag_pop;

  // ---------------- drain FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept_en = 1'b0;
    idle      = 1'b0;
    case (state)
      RUN: begin
        // Gated by reset so ready is low while reset is held, even with req up.
        if (drain) state_nxt = DRAIN;
        else       accept_en = reset;
      end
      DRAIN: begin
        if (!drain)                           state_nxt = RUN;
        else if (pipe_empty && !m_wr && !m_rd) state_nxt = IDLE;
      end
      IDLE: begin
        idle = 1'b1;
        if (!drain) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // ---------------- arbitration ----------------
`ifdef DMEM_ARB_RR_EN
  owner_e favour;

  always_comb begin
    grant_c = 1'b0;
    grant_l = 1'b0;
    if (accept_en) begin
      if (c_req && l_req) begin
        grant_c = (favour == OWN_CORE);
        grant_l = (favour == OWN_LDR);
      end else begin
        grant_c = c_req;
        grant_l = l_req;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       favour <= OWN_CORE;
    else if (grant_c) favour <= other_owner(OWN_CORE);
    else if (grant_l) favour <= other_owner(OWN_LDR);
  end
`else
  always_comb begin
    grant_c = accept_en && c_req;
    grant_l = accept_en && l_req && !c_req;
  end
`endif

  assign c_ready = grant_c;
  assign l_ready = grant_l;

  // ---------------- command register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_wr      <= 1'b0;
      m_rd      <= 1'b0;
      m_addr    <= '0;
      m_wr_data <= '0;
    end else begin
      m_wr <= 1'b0;
      m_rd <= 1'b0;
      if (grant_c) begin
        m_wr      <= c_we;
        m_rd      <= !c_we;
        m_addr    <= c_addr;
        m_wr_data <= c_wdata;
      end else if (grant_l) begin
        m_wr      <= l_we;
        m_rd      <= !l_we;
        m_addr    <= l_addr;
        m_wr_data <= l_wdata;
      end
    end
  end

  // ---------------- read return ----------------
  // The tag enters the pipe on the same edge as m_rd, so it reaches the last
  // stage exactly in the cycle m_rd_data is valid.
  always_comb begin
    tag_push.valid = (grant_c && !c_we) || (grant_l && !l_we);
    tag_push.owner = grant_l ? OWN_LDR : OWN_CORE;
  end

  dmem_rd_tag_pipe #(
    .DEPTH(RD_LAT + 1)
  ) u_tag_pipe (
    .clk  (clk),
    .rst_n(reset),
    .push (tag_push),
    .pop  (tag_pop),
    .empty(pipe_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
      c_rdata  <= '0;
      l_rdata  <= '0;
    end else begin
      c_rvalid <= tag_pop.valid && (tag_pop.owner == OWN_CORE);
      l_rvalid <= tag_pop.valid && (tag_pop.owner == OWN_LDR);
      if (tag_pop.valid && (tag_pop.owner == OWN_CORE)) c_rdata <= m_rd_data;
      if (tag_pop.valid && (tag_pop.owner == OWN_LDR))  l_rdata <= m_rd_data;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: drivers push expected commands/returns at
// accept time, a monitor pops and compares whenever the DUT presents output.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 9;
  localparam int RD_LAT   = 3;
  localparam int WAIT_MAX = 40;
  localparam int QUIET_MAX = 200;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                cyc;
  } cmd_exp_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } rsp_exp_t;

  logic              clk, reset, drain, idle;
  logic              c_req, c_we, c_ready, c_rvalid;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata;
  logic              l_req, l_we, l_ready, l_rvalid;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata, l_rdata;
  logic              m_wr, m_rd;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wr_data, m_rd_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  req_t     c_pend[$], l_pend[$];
  cmd_exp_t cmd_q[$];
  rsp_exp_t c_rsp_q[$], l_rsp_q[$];
  owner_e   grant_log[$];
  int       grant_cyc[$];
  int       l_rv_cyc[$];
  int       last_c_rv_cyc = -1;

  logic [DATA_W-1:0] mem     [2**ADDR_W];
  logic [DATA_W-1:0] ref_mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  logic c_active = 1'b0;
  logic l_active = 1'b0;
  req_t c_cur, l_cur;

  dmem_arbiter #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_ready  (c_ready),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .l_req    (l_req),
    .l_we     (l_we),
    .l_addr   (l_addr),
    .l_wdata  (l_wdata),
    .l_ready  (l_ready),
    .l_rvalid (l_rvalid),
    .l_rdata  (l_rdata),
    .m_wr     (m_wr),
    .m_rd     (m_rd),
    .m_addr   (m_addr),
    .m_wr_data(m_wr_data),
    .m_rd_data(m_rd_data),
    .drain    (drain),
    .idle     (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] init_word(input int a);
    return 32'h5A00_0000 ^ (a * 32'h0001_0101);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory with RD_LAT cycles from m_rd to valid m_rd_data.
  initial begin : mem_model
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = init_word(i);
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
    forever begin
      @(posedge clk);
      rd_pipe[0] <= m_rd ? mem[m_addr] : '0;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (m_wr) mem[m_addr] = m_wr_data;
    end
  end
  assign m_rd_data = rd_pipe[RD_LAT-1];

  task automatic record_accept(input owner_e o, input req_t r);
    grant_log.push_back(o);
    grant_cyc.push_back(cyc);
    cmd_q.push_back('{r.we, r.addr, r.wdata, cyc + 1});
    if (r.we) ref_mem[r.addr] = r.wdata;
    else if (o == OWN_CORE) c_rsp_q.push_back('{ref_mem[r.addr], cyc + 2 + RD_LAT});
    else                    l_rsp_q.push_back('{ref_mem[r.addr], cyc + 2 + RD_LAT});
  endtask

  // Request drivers: sample ready at negedge, update requests after posedge.
  initial begin : driver
    logic acc_c, acc_l;
    int   c_wait, l_wait;
    c_wait = 0;
    l_wait = 0;
    for (int i = 0; i < 2**ADDR_W; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (c_req || l_req || c_ready || l_ready)
        check("ready_legal", {c_ready && l_ready, c_ready && !c_req, l_ready && !l_req}, 3'b000);
      if (drain && (c_req || l_req))
        check("no_ready_in_drain", {c_ready, l_ready}, 2'b00);
      acc_c = c_active && c_ready;
      acc_l = l_active && l_ready;
      if (acc_c) record_accept(OWN_CORE, c_cur);
      if (acc_l) record_accept(OWN_LDR, l_cur);
      tick();
      if (acc_c) begin
        c_active = 1'b0;
        c_req    = 1'b0;
      end else if (c_active && ++c_wait > WAIT_MAX) begin
        check("core_accept_timeout", 1, 0);
        c_active = 1'b0;
        c_req    = 1'b0;
      end
      if (acc_l) begin
        l_active = 1'b0;
        l_req    = 1'b0;
      end else if (l_active && ++l_wait > WAIT_MAX) begin
        check("ldr_accept_timeout", 1, 0);
        l_active = 1'b0;
        l_req    = 1'b0;
      end
      if (!c_active && c_pend.size() > 0) begin
        c_cur = c_pend.pop_front();
        {c_req, c_we, c_addr, c_wdata} = {1'b1, c_cur.we, c_cur.addr, c_cur.wdata};
        c_active = 1'b1;
        c_wait   = 0;
      end
      if (!l_active && l_pend.size() > 0) begin
        l_cur = l_pend.pop_front();
        {l_req, l_we, l_addr, l_wdata} = {1'b1, l_cur.we, l_cur.addr, l_cur.wdata};
        l_active = 1'b1;
        l_wait   = 0;
      end
    end
  end

  // Monitor: compares every memory command and every read return.
  initial begin : monitor
    cmd_exp_t ec;
    rsp_exp_t er;
    forever begin
      @(negedge clk);
      if (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
        check("cmd_missing", cmd_q[0].cyc, cyc);
        void'(cmd_q.pop_front());
      end
      if (m_wr || m_rd) begin
        check("strobe_onehot", m_wr && m_rd, 0);
        if (cmd_q.size() == 0) check("unexpected_cmd", {m_wr, m_rd}, 2'b00);
        else begin
          ec = cmd_q.pop_front();
          check("cmd_we", m_wr, ec.we);
          check("cmd_addr", m_addr, ec.addr);
          if (ec.we) check("cmd_wdata", m_wr_data, ec.wdata);
          check("cmd_cycle", cyc, ec.cyc);
        end
      end
      if (c_rsp_q.size() > 0 && c_rsp_q[0].cyc < cyc) begin
        check("c_rvalid_missing", c_rsp_q[0].cyc, cyc);
        void'(c_rsp_q.pop_front());
      end
      if (l_rsp_q.size() > 0 && l_rsp_q[0].cyc < cyc) begin
        check("l_rvalid_missing", l_rsp_q[0].cyc, cyc);
        void'(l_rsp_q.pop_front());
      end
      if (c_rvalid) begin
        last_c_rv_cyc = cyc;
        if (c_rsp_q.size() == 0) check("unexpected_c_rvalid", c_rvalid, 0);
        else begin
          er = c_rsp_q.pop_front();
          check("c_rdata", c_rdata, er.data);
          check("c_rvalid_cycle", cyc, er.cyc);
        end
      end
      if (l_rvalid) begin
        l_rv_cyc.push_back(cyc);
        if (l_rsp_q.size() == 0) check("unexpected_l_rvalid", l_rvalid, 0);
        else begin
          er = l_rsp_q.pop_front();
          check("l_rdata", l_rdata, er.data);
          check("l_rvalid_cycle", cyc, er.cyc);
        end
      end
    end
  end

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((c_pend.size() > 0 || l_pend.size() > 0 || c_active || l_active ||
            cmd_q.size() > 0 || c_rsp_q.size() > 0 || l_rsp_q.size() > 0) && n < QUIET_MAX) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completes"}, n < QUIET_MAX, 1);
    tick();
  endtask

  task automatic wait_grants(input int n_grants);
    int n = 0;
    while (grant_log.size() < n_grants && n < QUIET_MAX) begin
      @(negedge clk);
      n++;
    end
    check("grants_seen", grant_log.size(), n_grants);
  endtask

  task automatic clear_logs();
    grant_log.delete();
    grant_cyc.delete();
    l_rv_cyc.delete();
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    repeat (2) tick();
    cmd_q.delete();
    c_rsp_q.delete();
    l_rsp_q.delete();
    reset = 1'b1;
    tick();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int d_cyc, idle_cyc, n, pulses;
    reset = 1'b0;
    drain = 1'b0;
    {c_req, c_we, c_addr, c_wdata} = {1'b1, 1'b0, 9'h005, 32'h0};
    {l_req, l_we, l_addr, l_wdata} = {1'b1, 1'b0, 9'h006, 32'h0};

    // Reset state, with both requests held high.
    repeat (2) @(negedge clk);
    check("rst_ready", {c_ready, l_ready}, 2'b00);
    check("rst_strobes", {m_wr, m_rd}, 2'b00);
    check("rst_m_bus", {m_addr, m_wr_data}, '0);
    check("rst_rvalid", {c_rvalid, l_rvalid}, 2'b00);
    check("rst_rdata", {c_rdata, l_rdata}, '0);
    check("rst_idle", idle, 0);
    tick();
    c_req = 1'b0;
    l_req = 1'b0;
    reset = 1'b1;
    tick();

    // Core write then read of the same word, back to back.
    clear_logs();
    c_pend.push_back('{1'b1, 9'h010, 32'hDEAD_BEEF});
    c_pend.push_back('{1'b0, 9'h010, 32'h0});
    wait_quiet("wr_rd");
    if (grant_cyc.size() == 2) check("wr_rd_back_to_back", grant_cyc[1] - grant_cyc[0], 1);
    check("wr_rd_data", c_rdata, 32'hDEAD_BEEF);

    // Simultaneous reads, four from each requester.
    do_reset();
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      c_pend.push_back('{1'b0, 9'h001, 32'h0});
      l_pend.push_back('{1'b0, 9'h002, 32'h0});
    end
    wait_quiet("arb");
    check("arb_grant_count", grant_log.size(), 8);
    if (grant_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
`ifdef DMEM_ARB_RR_EN
        check("rr_grant_order", grant_log[i], (i % 2 == 1) ? OWN_LDR : OWN_CORE);
`else
        check("fixed_grant_order", grant_log[i], (i < 4) ? OWN_CORE : OWN_LDR);
`endif
      end
      check("arb_no_bubbles", grant_cyc[7] - grant_cyc[0], 7);
    end
    check("arb_l_rdata", l_rdata, init_word(2));
    check("arb_c_rdata", c_rdata, init_word(1));

    // Eight back-to-back loader reads.
    clear_logs();
    for (int i = 0; i < 8; i++) l_pend.push_back('{1'b0, 9'h020 + 9'(i), 32'h0});
    wait_quiet("ldr_burst");
    check("ldr_burst_pulses", l_rv_cyc.size(), 8);
    if (l_rv_cyc.size() == 8) check("ldr_burst_no_gap", l_rv_cyc[7] - l_rv_cyc[0], 7);

    // Drain with two reads in flight, a loader write waiting.
    clear_logs();
    c_pend.push_back('{1'b0, 9'h030, 32'h0});
    c_pend.push_back('{1'b0, 9'h031, 32'h0});
    wait_grants(2);
    tick();
    drain = 1'b1;
    l_pend.push_back('{1'b1, 9'h040, 32'h1234_5678});
    @(negedge clk);
    check("drain_not_idle_yet", idle, 0);
    n = 0;
    while (!idle && n < QUIET_MAX) begin
      @(negedge clk);
      n++;
    end
    idle_cyc = cyc;
    check("drain_reaches_idle", idle, 1);
    check("idle_after_last_rvalid", idle_cyc, last_c_rv_cyc + 1);
    check("drain_no_extra_accept", grant_log.size(), 2);
    tick();
    drain = 1'b0;
    d_cyc = cyc;
    @(negedge clk);
    check("idle_until_resume", idle, 1);
    wait_quiet("resume");
    check("resume_grants", grant_log.size(), 3);
    if (grant_cyc.size() == 3) check("resume_cycle", grant_cyc[2], d_cyc + 1);
    check("resume_idle_low", idle, 0);

    // Reset one cycle after a read issues: the read must never return.
    clear_logs();
    c_pend.push_back('{1'b0, 9'h010, 32'h0});
    wait_grants(1);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_strobes", {m_wr, m_rd}, 2'b00);
    check("midrst_rvalid", {c_rvalid, l_rvalid}, 2'b00);
    check("midrst_rdata", {c_rdata, l_rdata}, '0);
    check("midrst_m_bus", {m_addr, m_wr_data}, '0);
    c_rsp_q.delete();
    l_rsp_q.delete();
    cmd_q.delete();
    repeat (2) tick();
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (c_rvalid || l_rvalid) pulses++;
    end
    check("midrst_no_rvalid", pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the core's load/store port and the program/data loader. It is pipelined, accepts at most one request per cycle and issues registered memory commands. Read data is steered back to the owning requester through a tag pipeline. A drain/quiesce handshake lets software or the bench hand the memory over cleanly. It sits between the datapath's memory interface (wr, rd, addr, wr_data, rd_data) and the data memory.

## Interface
- DATA_W, 32, data width
- ADDR_W, 9, word address width
- RD_LAT, 1, memory read latency in cycles from m_rd to valid m_rd_data; legal range 1..3
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- c_req / l_req  in  1  core / loader request valid, held until accepted
- c_we / l_we  in  1  1 = write, 0 = read
- c_addr / l_addr  in  ADDR_W  word address
- c_wdata / l_wdata  in  DATA_W  write data
- c_ready / l_ready  out  1  request accepted this cycle
- c_rvalid / l_rvalid  out  1  read data valid, one-cycle pulse
- c_rdata / l_rdata  out  DATA_W  read data
- m_wr, m_rd  out  1  memory write / read strobe
- m_addr  out  ADDR_W  memory address
- m_wr_data  out  DATA_W  memory write data
- m_rd_data  in  DATA_W  memory read data
- drain  in  1  stop accepting new requests
- idle  out  1  drained and no read in flight

## Operation
- Handshake: a request transfers in the cycle where xx_req && xx_ready. The requester keeps req, we, addr and wdata stable until then. xx_ready is never asserted without xx_req.
- Accept cycle T: the winner's command is registered. At T+1, exactly one of m_wr or m_rd is high, with m_addr and m_wr_data carrying the winner's values. Strobes are low in every cycle with no issue.
- Arbitration, default build: fixed priority, core wins. The loader is granted only in cycles with c_req low.
- Throughput: one accept per cycle, back-to-back, with no bubbles. Memory ordering equals accept order, so RAW/WAR across requesters is preserved.
- Read return: each issued read pushes the tag {valid, owner} into the tag pipe. When the tag emerges, m_rd_data is registered into the owner's xx_rdata and xx_rvalid pulses. The other requester's rvalid stays low, and its rdata holds its last value.
- Drain FSM, states RUN, DRAIN, IDLE:
  - RUN: accept normally. If drain = 1, go to DRAIN; no accept occurs in that cycle.
  - DRAIN: no accepts. When the tag pipe is empty and no command is pending, go to IDLE.
  - IDLE: idle = 1 and no accepts. If drain = 0, go to RUN; accepts resume in the following cycle.
  - If drain drops while in DRAIN, return to RUN.
- Reset values: all xx_ready, xx_rvalid, m_wr and m_rd are 0. m_addr, m_wr_data and xx_rdata are 0. FSM is in RUN, idle = 0, round-robin pointer favours core, tag pipe is cleared.
- Reset mid-operation: in-flight reads are discarded. No rvalid pulse appears after reset is released for reads issued before reset.

## Timing
- Write: accept T, m_wr at T+1.
- Read: accept T, m_rd at T+1, m_rd_data sampled at T+1+RD_LAT, xx_rvalid/xx_rdata at T+2+RD_LAT. With RD_LAT = 1, rvalid is at T+3.
- Tag pipe depth is RD_LAT+1, so up to RD_LAT+1 reads are outstanding without stall.
- idle rises one cycle after the last rvalid of a drain.
- Simultaneous requests: exactly one ready per cycle. The loser's ready stays 0, and its request stays pending.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - The pointer toggles to the other requester after each grant.
  - When both request, the requester not granted last wins.
  - A lone requester is always granted.
- DMEM_ARB_RR_EN undefined: fixed core-first priority. No pointer register is synthesized.

## Structure
- Package dmem_arb_pkg:
  - owner_e enum: OWN_CORE = 0, OWN_LDR = 1
  - rd_tag_t struct: {valid, owner}
  - drain_state_e enum: RUN, DRAIN, IDLE
- Sub-module dmem_rd_tag_pipe: parameterized shift register of rd_tag_t, depth RD_LAT+1, with async active-low clear and an empty output.

## Test plan
- Core write 0xDEADBEEF to addr 0x010, then read addr 0x010 on the next cycle → m_wr at T+1, m_rd at T+2, c_rvalid with c_rdata = 0xDEADBEEF at T+4 (RD_LAT = 1).
- Both request reads of 0x001/0x002 each cycle for 4 cycles:
  - Fixed build: core gets all 4 readies and loader gets none.
  - RR build: grants alternate C, L, C, L, each rvalid goes to the correct owner, and no cross-steering occurs.
- Back-to-back 8 loader reads with RD_LAT = 3 → 8 consecutive l_rvalid pulses with matching data, no gap after the first.
- Assert drain with 2 reads in flight → no further ready; idle rises one cycle after the second rvalid. Deassert drain → accepts resume next cycle.
- Pull reset low one cycle after a read is issued → all outputs go to reset values immediately. No rvalid appears in the 5 cycles after release.
